// File: rtl/uart_console_arbiter.sv
`timescale 1ns/1ps
// uart_console_arbiter
//   Shares one console character port between NUM_REQ requesters. The console
//   is locked to a single owner for a whole line (up to and including 8'h0a).
//   Ownership passes round-robin when the line ends, or when the owner has
//   sent nothing for TIMEOUT cycles. GAP idle cycles follow every accepted
//   char to pace the console.
//
//   Ports:
//     clock, reset         system clock, async active-high reset
//     req_valid[i]         requester i presents a char
//     req_ch[8i+7:8i]      char of requester i
//     req_ready[i]         char of requester i taken when valid & ready
//     io_uart_out_valid    one-cycle strobe per console char
//     io_uart_out_ch       console char
//     locked               an owner holds the console
//     owner                current owner index, 0 when not locked
//
//   state   | meaning
//   S_IDLE  | nobody owns the console; pick the next requester round-robin
//   S_LOCKED| owner streams one line; others are held off
module uart_console_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 256,
  parameter int GAP     = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_ch,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 io_uart_out_valid,
  output logic [7:0]           io_uart_out_ch,
  output logic                 locked,
  output logic [2:0]           owner
);

  localparam int TMO_W = $clog2(TIMEOUT);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t           state_q, state_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_ch_q, out_ch_d;
  logic [3:0]       gap_q, gap_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Requester buses padded to the 3-bit owner range so the owner index can
  // select from them directly for any NUM_REQ.
  logic [7:0]  valid_pad;
  logic [63:0] ch_pad;
  logic        own_valid;
  logic [7:0]  own_ch;
  logic        xfer;
  logic        grant_found;
  logic [2:0]  grant_idx;
  logic [2:0]  owner_next;

  always_comb begin
    valid_pad = '0;
    valid_pad[NUM_REQ-1:0] = req_valid;
    ch_pad = '0;
    ch_pad[8*NUM_REQ-1:0] = req_ch;
  end

  assign own_valid  = valid_pad[owner_q];
  assign own_ch     = ch_pad[{owner_q, 3'b000} +: 8];
  assign owner_next = (owner_q == 3'(NUM_REQ-1)) ? 3'd0 : owner_q + 3'd1;
  assign xfer       = (state_q == S_LOCKED) && (gap_q == 4'd0) && own_valid;

  // First valid requester starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [3:0] idx;
    idx         = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (!grant_found && valid_pad[idx[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[2:0];
      end
    end
  end

  // Ready comes only from registered state, never from req_valid.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = (state_q == S_LOCKED) && (gap_q == 4'd0) && (owner_q == 3'(i));
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    gap_d       = gap_q;
    tmo_d       = tmo_q;
    if (gap_q != 4'd0) gap_d = gap_q - 4'd1;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          state_d = S_LOCKED;
          owner_d = grant_idx;
          tmo_d   = '0;
          gap_d   = '0;
        end
      end
      S_LOCKED: begin
        if (xfer) begin
          out_valid_d = 1'b1;
          out_ch_d    = own_ch;
          gap_d       = 4'(GAP);
          tmo_d       = '0;
          if (own_ch == 8'h0a) begin
            state_d  = S_IDLE;
            owner_d  = '0;
            rr_ptr_d = owner_next;
          end
        end else if (gap_q == 4'd0) begin
          // A transfer in the same cycle takes priority over the timeout.
          if (tmo_q == TMO_W'(TIMEOUT-1)) begin
            state_d  = S_IDLE;
            owner_d  = '0;
            rr_ptr_d = owner_next;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
    end
  end

  assign io_uart_out_valid = out_valid_q;
  assign io_uart_out_ch    = out_ch_q;
  assign locked            = (state_q == S_LOCKED);
  assign owner             = owner_q;

endmodule

// File: tb/tb_uart_console_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_console_arbiter. Instance A (3 requesters, short timeout,
// no pacing) is fed from per-requester char queues; its expected console
// stream comes from a line-level round-robin model and is checked by a
// monitor. Instance B (2 requesters, GAP=3) covers console pacing.
module tb_uart_console_arbiter;
  localparam int NA = 3, TA = 8,  GA = 0;
  localparam int NB = 2, TB = 16, GB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NA-1:0]   vA, rdyA;
  logic [8*NA-1:0] chA;
  logic            oA_v, lkA;
  logic [7:0]      oA_ch;
  logic [2:0]      owA;

  logic [NB-1:0]   vB, rdyB;
  logic [8*NB-1:0] chB;
  logic            oB_v, lkB;
  logic [7:0]      oB_ch;
  logic [2:0]      owB;

  uart_console_arbiter #(.NUM_REQ(NA), .TIMEOUT(TA), .GAP(GA)) dut_a (
    .clock(clk), .reset(rst), .req_valid(vA), .req_ch(chA), .req_ready(rdyA),
    .io_uart_out_valid(oA_v), .io_uart_out_ch(oA_ch), .locked(lkA), .owner(owA));

  uart_console_arbiter #(.NUM_REQ(NB), .TIMEOUT(TB), .GAP(GB)) dut_b (
    .clock(clk), .reset(rst), .req_valid(vB), .req_ch(chB), .req_ready(rdyB),
    .io_uart_out_valid(oB_v), .io_uart_out_ch(oB_ch), .locked(lkB), .owner(owB));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;
  int m_rr  = 0;

  logic [7:0] src [NA][$];   // chars still to be offered by each requester
  logic [7:0] mq  [NA][$];   // model copy of the same chars
  logic [7:0] exp_q[$];      // expected console stream
  int st_cyc[$];             // cycles with a console strobe
  int hs_idx[$];             // requester index of each handshake
  int hs_cyc[$];             // cycle of each handshake

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endfunction

  function automatic bit src_busy();
    for (int i = 0; i < NA; i++) if (src[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void load(int i, string s);
    for (int j = 0; j < s.len(); j++) begin
      src[i].push_back(s[j]);
      mq[i].push_back(s[j]);
    end
  endfunction

  // Line-level model: whole lines are emitted one at a time, the next line
  // going to the first requester at or after the rotating preference that
  // still has chars pending.
  function automatic void model_run();
    bit any;
    int idx;
    logic [7:0] b;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int k = 0; k < NA && !any; k++) begin
        idx = (m_rr + k) % NA;
        if (mq[idx].size() > 0) begin
          any = 1'b1;
          while (mq[idx].size() > 0) begin
            b = mq[idx].pop_front();
            exp_q.push_back(b);
            if (b == 8'h0a) break;
          end
          m_rr = (idx + 1) % NA;
        end
      end
    end
  endfunction

  function automatic void clear_logs();
    st_cyc.delete();
    hs_idx.delete();
    hs_cyc.delete();
  endfunction

  function automatic void clear_src();
    for (int i = 0; i < NA; i++) begin
      src[i].delete();
      mq[i].delete();
    end
  endfunction

  // Requester driver for instance A.
  initial begin
    vA  = '0;
    chA = '0;
    forever begin
      @(negedge clk);
      if (!rst)
        for (int i = 0; i < NA; i++)
          if (vA[i] && rdyA[i]) begin
            if (src[i].size() > 0) void'(src[i].pop_front());
            hs_idx.push_back(i);
            hs_cyc.push_back(cyc);
          end
      @(posedge clk);
      #2;
      for (int i = 0; i < NA; i++)
        if (src[i].size() > 0) begin
          vA[i] = 1'b1;
          chA[8*i +: 8] = src[i][0];
        end else begin
          vA[i] = 1'b0;
          chA[8*i +: 8] = 8'h00;
        end
    end
  end

  // Console monitor for instance A.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rdyA != '0 && rdyA != NA'(1 << owA)) viol++;
        if (oA_v) begin
          st_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected_char: got %0d expected none", oA_ch);
          end else begin
            e = exp_q.pop_front();
            chk("sb_char", oA_ch, e);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_src();
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    m_rr = 0;
  endtask

  task automatic wait_done(string name, int budget);
    int n;
    n = 0;
    while ((src_busy() || exp_q.size() > 0 || lkA) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_completes"}, int'(n < budget), 1);
    @(negedge clk);
  endtask

  int t0, n, h, lowc, nst, posB, last_st, last_hs, nl, len;
  string line, pace_s;

  initial begin
    rst = 1'b1;
    vB  = '0;
    chB = '0;
    repeat (3) @(negedge clk);
    chk("rst_outA_valid", oA_v, 0);
    chk("rst_outA_ch", oA_ch, 0);
    chk("rst_lockedA", lkA, 0);
    chk("rst_ownerA", owA, 0);
    chk("rst_readyA", rdyA, 0);
    chk("rst_lockedB", lkB, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_readyA", rdyA, 0);
    chk("idle_lockedA", lkA, 0);

    // Single requester: "hi\n".
    @(posedge clk); #1;
    clear_logs();
    t0 = cyc;
    load(0, "hi\n");
    model_run();
    wait_done("hi", 50);
    chk("hi_strobes", st_cyc.size(), 3);
    if (st_cyc.size() == 3) begin
      chk("hi_first_latency", st_cyc[0] - t0, 2);
      chk("hi_spacing1", st_cyc[1] - st_cyc[0], 1);
      chk("hi_spacing2", st_cyc[2] - st_cyc[1], 1);
    end
    chk("hi_unlocked", lkA, 0);

    // Line atomicity: two requesters, lines must not interleave.
    do_reset();
    @(posedge clk); #1;
    clear_logs();
    load(0, "AB\n");
    load(1, "cd\n");
    model_run();
    wait_done("atom", 60);
    chk("atom_hs_count", hs_idx.size(), 6);
    if (hs_idx.size() == 6)
      for (int k = 0; k < 6; k++) chk($sformatf("atom_hs%0d", k), hs_idx[k], (k < 3) ? 0 : 1);

    // Round-robin fairness with one-char lines.
    do_reset();
    @(posedge clk); #1;
    clear_logs();
    for (int i = 0; i < NA; i++) load(i, "\n\n");
    model_run();
    wait_done("rr", 80);
    chk("rr_hs_count", hs_idx.size(), 6);
    if (hs_idx.size() == 6)
      for (int k = 0; k < 6; k++) chk($sformatf("rr_hs%0d", k), hs_idx[k], k % NA);

    // Timeout: req1 sends "x" and stops; req0 waits behind it.
    do_reset();
    @(posedge clk); #1;
    clear_logs();
    src[1].push_back(8'h78);
    exp_q.push_back(8'h78);
    n = 0;
    while (hs_idx.size() == 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tmo_x_accepted", hs_idx.size(), 1);
    h = (hs_cyc.size() > 0) ? hs_cyc[0] : 0;
    load(0, "z\n");
    m_rr = 2;
    model_run();
    lowc = -1;
    n = 0;
    while (lowc < 0 && n < 40) begin
      @(negedge clk);
      if (!lkA) lowc = cyc;
      n++;
    end
    chk("tmo_release_cycle", lowc - h, TA + 1);
    wait_done("tmo", 60);
    chk("tmo_hs_count", hs_idx.size(), 3);
    if (hs_idx.size() == 3)
      for (int k = 0; k < 3; k++) chk($sformatf("tmo_hs%0d", k), hs_idx[k], (k == 0) ? 1 : 0);

    // Async reset in the middle of "hello\n" (preference now points at 1).
    @(posedge clk); #1;
    clear_logs();
    src[0].push_back(8'h68); src[0].push_back(8'h65); src[0].push_back(8'h6c);
    src[0].push_back(8'h6c); src[0].push_back(8'h6f); src[0].push_back(8'h0a);
    exp_q.push_back(8'h68);
    n = 0;
    while (st_cyc.size() == 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("arst_first_char_seen", st_cyc.size(), 1);
    rst = 1'b1;
    clear_src();
    #1;
    chk("arst_out_valid", oA_v, 0);
    chk("arst_locked", lkA, 0);
    chk("arst_ready", rdyA, 0);
    chk("arst_owner", owA, 0);
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    m_rr = 0;
    @(posedge clk); #1;
    clear_logs();
    load(1, "q\n");
    load(0, "p\n");
    model_run();
    wait_done("arst", 60);
    chk("arst_hs_count", hs_idx.size(), 4);
    if (hs_idx.size() == 4)
      for (int k = 0; k < 4; k++) chk($sformatf("arst_hs%0d", k), hs_idx[k], (k < 2) ? 0 : 1);

    // Randomised rounds of variable-length lines from all requesters.
    for (int r = 0; r < 8; r++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NA; i++) begin
        nl = $urandom_range(0, 3);
        for (int l = 0; l < nl; l++) begin
          line = "";
          len = $urandom_range(0, 4);
          for (int c = 0; c < len; c++) line = {line, string'(8'($urandom_range(32, 126)))};
          line = {line, "\n"};
          load(i, line);
        end
      end
      model_run();
      wait_done($sformatf("rand%0d", r), 400);
    end

    // Pacing on instance B: "abc\n" with GAP=3.
    pace_s = "abc\n";
    @(posedge clk); #2;
    t0 = cyc;
    vB = 2'b01;
    chB[7:0] = pace_s[0];
    nst = 0; posB = 0; last_st = 0; last_hs = 0;
    for (int k = 0; k < 80 && nst < 4; k++) begin
      @(negedge clk);
      if (oB_v) begin
        if (nst < 4) chk($sformatf("pace_char%0d", nst), oB_ch, pace_s[nst]);
        if (nst == 0) chk("pace_first_latency", cyc - t0, 2);
        else chk($sformatf("pace_strobe_gap%0d", nst), cyc - last_st, GB + 1);
        if (nst < 3) chk($sformatf("pace_lock_held%0d", nst), lkB, 1);
        last_st = cyc;
        nst++;
      end
      if (vB[0] && rdyB[0]) begin
        if (posB > 0) chk($sformatf("pace_ready_gap%0d", posB), cyc - last_hs, GB + 1);
        last_hs = cyc;
        posB++;
      end
      @(posedge clk); #2;
      if (posB < 4) chB[7:0] = pace_s[posB];
      else vB = '0;
    end
    chk("pace_strobes", nst, 4);
    repeat (2) @(negedge clk);
    chk("pace_unlocked", lkB, 0);

    chk("ready_onehot_violations", viol, 0);
    chk("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
